// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM pattern test engine: pattern modes,
// controller states and Galois LFSR feedback taps per supported data width.
package sram_test_pkg;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_NADDR = 2'd1,
    PAT_CONST = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [31:0] LFSR_TAP_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAP_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAP_32 = 32'h8020_0003;

  // Right-shifting Galois feedback mask for the given data width.
  function automatic logic [31:0] lfsr_tap(input int unsigned width);
    logic [31:0] tap;
    case (width)
      32'd8:   tap = LFSR_TAP_8;
      32'd16:  tap = LFSR_TAP_16;
      default: tap = LFSR_TAP_32;
    endcase
    return tap;
  endfunction

endpackage

// File: rtl/sram_pattern_engine_if.sv
// Request/acknowledge port between the pattern engine and the SRAM controller.
interface sram_pattern_engine_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              sram_req;
  logic              sram_rh_wl;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_w;
  logic              sram_ack;
  logic [DATA_W-1:0] sram_data_r;

  modport master (
    output sram_req, sram_rh_wl, sram_addr, sram_data_w,
    input  sram_ack, sram_data_r
  );

  modport slave (
    input  sram_req, sram_rh_wl, sram_addr, sram_data_w,
    output sram_ack, sram_data_r
  );
endinterface

// File: rtl/sram_pattern_gen.sv
// Pattern generator: produces the word for the current address from the
// selected mode. The LFSR is reloaded from the seed at the start of each pass
// and advanced once per completed word, so both passes see the same sequence.
module sram_pattern_gen
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  pat_mode_e         mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              adv,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] TAP = DATA_W'(lfsr_tap(DATA_W));

  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_d;
  logic [DATA_W-1:0] addr_pat;

  assign addr_pat = DATA_W'(addr);

  // LFSR next state: reload (zero seed forced to all-ones) or one Galois step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? '1 : seed;
    end else if (adv) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAP : '0);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Pattern select for the current address.
  always_comb begin
    data = '0;
    case (mode)
      PAT_ADDR:  data = addr_pat;
      PAT_NADDR: data = ~addr_pat;
      PAT_CONST: data = seed;
      PAT_LFSR:  data = lfsr_q;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/sram_pattern_engine.sv
// Autonomous SRAM test engine: writes a pattern over [cfg_start, cfg_end],
// reads it back, counts miscompares and records the first failing word.
// An ack watchdog bounds every wait; abort drains the outstanding access.
module sram_pattern_engine
  import sram_test_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    cfg_start,
  input  logic [ADDR_W-1:0]    cfg_end,
  input  logic [1:0]           cfg_mode,
  input  logic [DATA_W-1:0]    cfg_seed,
  sram_pattern_engine_if.master sram,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data,
  output logic [DATA_W-1:0]    first_err_exp
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  pat_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0] fe_data_q, fe_data_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d;

  logic              gen_load;
  logic              gen_adv;
  logic [DATA_W-1:0] gen_seed;
  logic [DATA_W-1:0] pat_data;
  logic              mismatch;

  // The seed is taken straight from config on the start cycle, before it is latched.
  assign gen_seed = (state_q == ST_IDLE) ? cfg_seed : seed_q;

  sram_pattern_gen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_gen (
    .clk   (clk),
    .reset (reset),
    .mode  (mode_q),
    .seed  (gen_seed),
    .addr  (cur_q),
    .load  (gen_load),
    .adv   (gen_adv),
    .data  (pat_data)
  );

  // Next-state, sequencing, watchdog and result bookkeeping.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    wd_d         = wd_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    err_d        = err_q;
    fe_addr_d    = fe_addr_q;
    fe_data_d    = fe_data_q;
    fe_exp_d     = fe_exp_q;
    gen_load     = 1'b0;
    gen_adv      = 1'b0;
    mismatch     = (sram.sram_data_r != pat_data);

    case (state_q)
      ST_IDLE: begin
        // abort takes precedence over a simultaneous start
        if (start && !abort) begin
          start_addr_d = cfg_start;
          end_addr_d   = cfg_end;
          mode_d       = pat_mode_e'(cfg_mode);
          seed_d       = cfg_seed;
          cur_d        = cfg_start;
          wd_d         = '0;
          gen_load     = 1'b1;
          timeout_d    = 1'b0;
          err_d        = '0;
          fe_addr_d    = '0;
          fe_data_d    = '0;
          fe_exp_d     = '0;
          if (cfg_end < cfg_start) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_WR_REQ;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_REQ, ST_RD_REQ: begin
        // the request is issued this cycle regardless of abort
        wd_d = '0;
        if (abort) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end
      end

      ST_WR_WAIT: begin
        if (sram.sram_ack) begin
          wd_d = '0;
          if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (cur_q == end_addr_q) begin
            cur_d    = start_addr_q;
            gen_load = 1'b1;
            state_d  = ST_RD_REQ;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            gen_adv = 1'b1;
            state_d = ST_WR_REQ;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end else begin
          wd_d    = wd_q + WD_W'(1);
          state_d = abort ? ST_DRAIN : ST_WR_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (sram.sram_ack) begin
          wd_d = '0;
          if (mismatch) begin
            err_d = (err_q == '1) ? err_q : err_q + CNT_W'(1);
            if (err_q == '0) begin
              fe_addr_d = cur_q;
              fe_data_d = sram.sram_data_r;
              fe_exp_d  = pat_data;
            end else begin
              fe_addr_d = fe_addr_q;
            end
          end else begin
            err_d = err_q;
          end
          if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (cur_q == end_addr_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0) && !timeout_q;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            gen_adv = 1'b1;
            state_d = ST_RD_REQ;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end else begin
          wd_d    = wd_q + WD_W'(1);
          state_d = abort ? ST_DRAIN : ST_RD_WAIT;
        end
      end

      ST_DRAIN: begin
        // wait out the outstanding access, then return idle without done
        if (sram.sram_ack) begin
          wd_d    = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (wd_q == WD_LAST) begin
          wd_d      = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      mode_q       <= PAT_ADDR;
      seed_q       <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= '0;
      fe_addr_q    <= '0;
      fe_data_q    <= '0;
      fe_exp_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
      fe_addr_q    <= fe_addr_d;
      fe_data_q    <= fe_data_d;
      fe_exp_q     <= fe_exp_d;
    end
  end

  // Request strobes decode the registered state; address is the registered cursor.
  always_comb begin
    sram.sram_req    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    sram.sram_rh_wl  = (state_q == ST_RD_REQ);
    sram.sram_addr   = cur_q;
    sram.sram_data_w = (state_q == ST_WR_REQ) ? pat_data : '0;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;

endmodule

// File: tb/tb_sram_pattern_engine.sv
// Directed bench for sram_pattern_engine: table of full test runs against an
// SRAM model with optional stuck-at-1 on bit 3, plus timeout, abort/drain,
// start-while-busy and start+abort sequences.
module tb_sram_pattern_engine;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] cfg_start;
  logic [AW-1:0] cfg_end;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
  logic [DW-1:0] first_err_exp;

  sram_pattern_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_pattern_engine #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(255)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_start      (cfg_start),
    .cfg_end        (cfg_end),
    .cfg_mode       (cfg_mode),
    .cfg_seed       (cfg_seed),
    .sram           (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .first_err_exp  (first_err_exp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // SRAM model state
  logic [7:0]    mem [int unsigned];
  int            ncyc = 0;
  int            n_wr = 0;
  int            n_rd = 0;
  int            first_req_n = 0;
  logic [7:0]    first_wdata = 8'h00;
  int            ack_dly = 2;
  bit            ack_en = 1'b1;
  bit            pend = 1'b0;
  int            pend_cnt = 0;
  logic [7:0]    pend_data = 8'h00;
  bit            stuck_en = 1'b0;
  logic [AW-1:0] stuck_lo = '0;
  logic [AW-1:0] stuck_hi = '0;

  // SRAM model: sees req at negedge, acks ack_dly cycles later.
  always @(negedge clk) begin
    ncyc++;
    bus.sram_ack = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend = 1'b0;
        if (ack_en) begin
          bus.sram_ack    = 1'b1;
          bus.sram_data_r = pend_data;
        end
      end
    end
    if (bus.sram_req === 1'b1) begin
      if (n_wr + n_rd == 0) first_req_n = ncyc;
      pend     = 1'b1;
      pend_cnt = ack_dly;
      if (bus.sram_rh_wl) begin
        n_rd++;
        pend_data = mem.exists(int'(bus.sram_addr)) ? mem[int'(bus.sram_addr)] : 8'h00;
        if (stuck_en && bus.sram_addr >= stuck_lo && bus.sram_addr <= stuck_hi)
          pend_data = pend_data | 8'h08;
      end else begin
        if (n_wr == 0) first_wdata = bus.sram_data_w;
        n_wr++;
        mem[int'(bus.sram_addr)] = bus.sram_data_w;
        pend_data = 8'h00;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    pend     = 1'b0;
    pend_cnt = 0;
    n_wr     = 0;
    n_rd     = 0;
    first_req_n = 0;
    first_wdata = 8'h00;
    stuck_en = 1'b0;
    mem.delete();
  endtask

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    logic [1:0]    mode;
    logic [7:0]    seed;
    bit            st_en;
    logic [AW-1:0] st_lo;
    logic [AW-1:0] st_hi;
    bit            exp_pass;
    int            exp_err;
    logic [AW-1:0] exp_fa;
    logic [7:0]    exp_fd;
    logic [7:0]    exp_fe;
    int            exp_wr;
    int            exp_rd;
    logic [7:0]    exp_w0;
  } vec_t;

  vec_t vt [8];

  // Pulse start for one cycle with the given config; returns ncyc after the start edge.
  task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic [1:0] m, input logic [7:0] sd, output int s_n);
    @(posedge clk); #1;
    cfg_start = s; cfg_end = e; cfg_mode = m; cfg_seed = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_n = ncyc;
  endtask

  task automatic wait_done(input int budget, output int k, output bit got);
    got = 1'b0;
    k = 0;
    while (k < budget) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_test(input int idx, input vec_t v);
    int  s_n;
    int  k;
    bit  got;
    string t;
    model_clear();
    stuck_en = v.st_en;
    stuck_lo = v.st_lo;
    stuck_hi = v.st_hi;
    pulse_start(v.s, v.e, v.mode, v.seed, s_n);
    wait_done(3000, k, got);
    t = $sformatf("v%0d", idx);
    chk({t, "_done"}, 32'(got), 32'd1);
    chk({t, "_pass"}, 32'(pass), 32'(v.exp_pass));
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_timeout"}, 32'(timeout), 32'd0);
    chk({t, "_err_count"}, 32'(err_count), 32'(v.exp_err));
    chk({t, "_first_err_addr"}, 32'(first_err_addr), 32'(v.exp_fa));
    chk({t, "_first_err_data"}, 32'(first_err_data), 32'(v.exp_fd));
    chk({t, "_first_err_exp"}, 32'(first_err_exp), 32'(v.exp_fe));
    chk({t, "_writes"}, 32'(n_wr), 32'(v.exp_wr));
    chk({t, "_reads"}, 32'(n_rd), 32'(v.exp_rd));
    if (v.exp_wr > 0) begin
      chk({t, "_first_wdata"}, 32'(first_wdata), 32'(v.exp_w0));
      chk({t, "_first_req_lat"}, 32'(first_req_n - s_n), 32'd1);
    end else begin
      chk({t, "_empty_done_lat"}, 32'(k), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  s_n;
    int  k;
    bit  got;

    vt[0] = '{19'h00010, 19'h0001F, 2'd0, 8'h00, 1'b0, 19'h0, 19'h0, 1'b1, 0, 19'h0, 8'h00, 8'h00, 16, 16, 8'h10};
    vt[1] = '{19'h00010, 19'h0001F, 2'd0, 8'h00, 1'b1, 19'h00014, 19'h00014, 1'b0, 1, 19'h00014, 8'h1C, 8'h14, 16, 16, 8'h10};
    vt[2] = '{19'h7FFFE, 19'h7FFFF, 2'd3, 8'h00, 1'b0, 19'h0, 19'h0, 1'b1, 0, 19'h0, 8'h00, 8'h00, 2, 2, 8'hFF};
    vt[3] = '{19'h00028, 19'h0002B, 2'd1, 8'h00, 1'b1, 19'h00029, 19'h00029, 1'b0, 1, 19'h00029, 8'hDE, 8'hD6, 4, 4, 8'hD7};
    vt[4] = '{19'h00100, 19'h00103, 2'd2, 8'hA5, 1'b1, 19'h00101, 19'h00103, 1'b0, 3, 19'h00101, 8'hAD, 8'hA5, 4, 4, 8'hA5};
    vt[5] = '{19'h00009, 19'h00005, 2'd0, 8'h00, 1'b0, 19'h0, 19'h0, 1'b1, 0, 19'h0, 8'h00, 8'h00, 0, 0, 8'h00};
    vt[6] = '{19'h00000, 19'h00000, 2'd0, 8'h00, 1'b0, 19'h0, 19'h0, 1'b1, 0, 19'h0, 8'h00, 8'h00, 1, 1, 8'h00};
    vt[7] = '{19'h00000, 19'h00003, 2'd3, 8'h01, 1'b1, 19'h00000, 19'h00003, 1'b0, 1, 19'h00000, 8'h09, 8'h01, 4, 4, 8'h01};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_start = '0;
    cfg_end = '0;
    cfg_mode = 2'd0;
    cfg_seed = 8'h00;
    bus.sram_ack = 1'b0;
    bus.sram_data_r = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.sram_req), 32'd0);
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_data_w", 32'(bus.sram_data_w), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_err_addr", 32'(first_err_addr), 32'd0);
    chk("rst_first_err_data", 32'(first_err_data), 32'd0);
    chk("rst_first_err_exp", 32'(first_err_exp), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_test(i, vt[i]);

    // Never-acking SRAM: watchdog fires after 255 wait cycles.
    model_clear();
    ack_en = 1'b0;
    pulse_start(19'h00000, 19'h00003, 2'd0, 8'h00, s_n);
    k = 0;
    got = 1'b0;
    while (k < 400) begin
      @(posedge clk); #1;
      k++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("to_done", 32'(got), 32'd1);
    chk("to_cycles", 32'(k), 32'd256);
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_pass", 32'(pass), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_writes", 32'(n_wr), 32'd1);
    ack_en = 1'b1;
    model_clear();

    // Abort during WR_WAIT, ack arrives 3 cycles after the request.
    ack_dly = 3;
    pulse_start(19'h00000, 19'h0000F, 2'd0, 8'h00, s_n);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_busy_drain1", 32'(busy), 32'd1);
    chk("ab_req_drain", 32'(bus.sram_req), 32'd0);
    @(posedge clk); #1;
    chk("ab_busy_drain2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("ab_busy_after", 32'(busy), 32'd0);
    chk("ab_done_after", 32'(done), 32'd0);
    chk("ab_timeout", 32'(timeout), 32'd0);
    chk("ab_writes", 32'(n_wr), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("ab_idle_writes", 32'(n_wr), 32'd1);
    ack_dly = 2;
    run_test(10, vt[0]);

    // start while busy is ignored.
    model_clear();
    pulse_start(19'h00010, 19'h0001F, 2'd0, 8'h00, s_n);
    repeat (5) @(posedge clk);
    #1;
    cfg_start = 19'h00040;
    cfg_end = 19'h00040;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3000, k, got);
    chk("sb_done", 32'(got), 32'd1);
    chk("sb_writes", 32'(n_wr), 32'd16);
    chk("sb_reads", 32'(n_rd), 32'd16);
    chk("sb_pass", 32'(pass), 32'd1);

    // start and abort together in IDLE: nothing starts, done holds.
    model_clear();
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy_now", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_writes", 32'(n_wr), 32'd0);
    chk("sa_done_held", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
